// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter with round-robin grants and atomic CYC bursts.
// Optional stalled-strobe watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [63:0] m_adr_i,
  input  logic [63:0] m_dat_i,
  input  logic [5:0]  m_cti_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [1:0]  m_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [2:0]  s_cti_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  gnt_o
);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   own;
  logic   own_cyc;
  logic   own_stb;
  logic   timeout;
  logic   hold;

  assign own     = (state_q == StOwn1);
  assign own_cyc = (state_q != StIdle) & m_cyc_i[own];
  assign own_stb = own_cyc & m_stb_i[own];
  assign hold    = own_cyc & ~timeout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wd_q, wd_d;
  logic            resp;

  assign resp    = s_ack_i | s_err_i | s_rty_i;
  // Stall detection uses the unforced strobe so the forced drop cannot feed back.
  assign timeout = own_stb & ~resp & (wd_q == WdLast);

  always_comb begin
    wd_d = wd_q;
    if (state_q == StIdle || resp || state_d != state_q) begin
      wd_d = '0;
    end else if (own_stb) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m_cyc_i == 2'b11) begin
          state_d = last_gnt_q ? StOwn0 : StOwn1;
        end else if (m_cyc_i[0]) begin
          state_d = StOwn0;
        end else if (m_cyc_i[1]) begin
          state_d = StOwn1;
        end
      end
      // Owner keeps the bus until it drops CYC; a waiting peer gets a direct handoff.
      StOwn0: if (!hold) state_d = m_cyc_i[1] ? StOwn1 : StIdle;
      StOwn1: if (!hold) state_d = m_cyc_i[0] ? StOwn0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_d == StOwn0 && state_q != StOwn0) begin
      last_gnt_d = 1'b0;
    end else if (state_d == StOwn1 && state_q != StOwn1) begin
      last_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign gnt_o = state_q;

  always_comb begin
    s_cyc_o = own_cyc & ~timeout;
    s_stb_o = own_stb & ~timeout;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    if (state_q != StIdle) begin
      s_we_o  = m_we_i[own];
      s_adr_o = own ? m_adr_i[63:32] : m_adr_i[31:0];
      s_dat_o = own ? m_dat_i[63:32] : m_dat_i[31:0];
      s_cti_o = own ? m_cti_i[5:3]   : m_cti_i[2:0];
    end
  end

  // Responses after the owner drops CYC are discarded.
  assign m_ack_o = gnt_o & {2{own_cyc & s_ack_i}};
  assign m_rty_o = gnt_o & {2{own_cyc & s_rty_i}};
  assign m_err_o = gnt_o & {2{(own_cyc & s_err_i) | timeout}};
  assign m_dat_o = rst ? 32'h0 : s_dat_i;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter; the watchdog section runs only with WB_ARB_TIMEOUT_EN.
module tb_wb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [63:0] m_adr_i, m_dat_i;
  logic [5:0]  m_cti_i;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [2:0]  s_cti_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_cti_i (m_cti_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_cti_o (s_cti_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .gnt_o   (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_cti_i = '0;
    s_dat_i = 32'h1234_5678; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    #3;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 1'b0);
    chk("rst_mdat", m_dat_o, 32'h0);
    rst = 1'b0;
    s_dat_i = '0;

    // m0 alone: one-cycle grant latency, ACK and data routed to m0 only
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h100; m_dat_i[31:0] = 32'hCAFE;
    #1;
    chk("m0_pre_gnt", gnt_o, 2'b00);
    chk("m0_pre_scyc", s_cyc_o, 1'b0);
    step();
    chk("m0_gnt", gnt_o, 2'b01);
    chk("m0_sadr", s_adr_o, 32'h100);
    chk("m0_sdat", s_dat_o, 32'hCAFE);
    chk("m0_sstb", {s_cyc_o, s_stb_o}, 2'b11);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("m0_ack", m_ack_o, 2'b01);
    chk("m0_mdat", m_dat_o, 32'hDEAD_BEEF);
    step();
    s_ack_i = 1'b0; m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    chk("m0_idle", gnt_o, 2'b00);

    // reset restores last_gnt so m0 wins the first tie
    rst = 1'b1; #1; rst = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_adr_i = {32'hB0, 32'hA0};
    step();
    chk("tie_gnt0", gnt_o, 2'b01);
    chk("tie_adr0", s_adr_o, 32'hA0);
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    #1;
    chk("drop_scyc", s_cyc_o, 1'b0);
    step();
    chk("handoff_gnt1", gnt_o, 2'b10);
    chk("handoff_adr1", s_adr_o, 32'hB0);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    chk("m1_hold", gnt_o, 2'b10);
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    chk("alt_gnt0", gnt_o, 2'b01);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    chk("alt_gnt1", gnt_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    chk("alt_idle", gnt_o, 2'b00);

    // four-beat m0 burst while m1 waits; last_gnt=1 so m0 wins
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_cti_i = {3'b000, 3'b010};
    step();
    chk("burst_gnt", gnt_o, 2'b01);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti_i[2:0] = 3'b111;
      s_ack_i = 1'b1;
      #1;
      chk("burst_ack", m_ack_o, 2'b01);
      chk("burst_cti", s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      step();
      chk("burst_gnt_hold", gnt_o, 2'b01);
    end
    s_ack_i = 1'b0; s_rty_i = 1'b1;
    #1;
    chk("rty_route", m_rty_o, 2'b01);
    s_rty_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10; m_cti_i = '0;
    step();
    chk("burst_m1", gnt_o, 2'b10);

    // stray responses
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
    s_ack_i = 1'b1;
    #1;
    chk("stray_ack", m_ack_o, 2'b00);
    step();
    chk("stray_idle", gnt_o, 2'b00);
    s_ack_i = 1'b0; m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    chk("err_own1", gnt_o, 2'b10);
    m_cyc_i = 2'b00; m_stb_i = 2'b00; s_err_i = 1'b1;
    #1;
    chk("drop_err", m_err_o, 2'b00);
    step();
    s_err_i = 1'b0;
    chk("drop_idle", gnt_o, 2'b00);

    // async reset mid-transfer
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    chk("ar_own1", {gnt_o, s_stb_o}, 3'b101);
    rst = 1'b1;
    #1;
    chk("ar_bus", {s_cyc_o, s_stb_o}, 2'b00);
    chk("ar_gnt", gnt_o, 2'b00);
    rst = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    chk("ar_tie", gnt_o, 2'b01);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // m1 stalls; watchdog fires on the 8th stalled cycle and hands off to m0
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    step();
    chk("wd_gnt1", gnt_o, 2'b10);
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    for (int c = 1; c < 8; c++) begin
      #1;
      chk("wd_quiet", {m_err_o, s_cyc_o}, 3'b001);
      step();
    end
    #1;
    chk("wd_err", m_err_o, 2'b10);
    chk("wd_force", {s_cyc_o, s_stb_o}, 2'b00);
    step();
    chk("wd_handoff", gnt_o, 2'b01);
    chk("wd_err_clr", m_err_o, 2'b00);
    m_cyc_i = 2'b00; m_stb_i = 2'b00;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
